// File: rtl/if_id_skid_reg_if.sv
// rtl/if_id_skid_reg_if.sv - fetch-side and decode-side handshake bundle for the IF/ID skid stage
interface if_id_skid_reg_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [ILEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - 2-entry IF/ID skid register with registered in_ready and sync flush
module if_id_skid_reg #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  if_id_skid_reg_if.slave   bus
);
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [ILEN-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic            in_fire, out_fire, out_valid_w;

  assign out_valid_w   = (state_q != S_EMPTY);
  assign in_fire       = bus.in_valid & in_ready_q;
  assign out_fire      = out_valid_w & bus.out_ready;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_w;
  assign bus.out_pc    = main_pc_q;
  assign bus.out_instr = main_instr_q;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    // Flush wins over both handshakes; main keeps its contents so the bubble shows stale data.
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d      = S_ONE;
            main_pc_d    = bus.in_pc;
            main_instr_d = bus.in_instr;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_pc_d    = bus.in_pc;
            main_instr_d = bus.in_instr;
          end else if (in_fire) begin
            state_d      = S_TWO;
            skid_pc_d    = bus.in_pc;
            skid_instr_d = bus.in_instr;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d      = S_ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    // Computed from next state so in_ready is a flop output with no path from out_ready.
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_EMPTY;
      in_ready_q   <= 1'b1;
      main_pc_q    <= '0;
      main_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - directed and streaming checks for the IF/ID skid register
module tb_if_id_skid_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  if_id_skid_reg_if #(.XLEN(32), .ILEN(32)) bus ();

  if_id_skid_reg #(.XLEN(32), .ILEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h100;
    bus.in_instr  = 32'h0000_0013;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL single_out_pc got %h want 100", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h0000_0013) begin errors++; $display("FAIL single_out_instr got %h want 00000013", bus.out_instr); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL bubble_keeps_pc got %h want 100", bus.out_pc); end
  endtask

  task automatic fill_two();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h100;
    bus.in_instr  = 32'hAAAA_0100;
    tick();
    bus.in_pc     = 32'h104;
    bus.in_instr  = 32'hAAAA_0104;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_backpressure();
    fill_two();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %0b want 0", bus.in_ready); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL bp_hold_pc got %h want 100", bus.out_pc); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_instr !== 32'hAAAA_0100) begin
      errors++; $display("FAIL bp_stable got v=%0b pc=%h instr=%h want v=1 pc=100 instr=aaaa0100", bus.out_valid, bus.out_pc, bus.out_instr);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104) begin errors++; $display("FAIL bp_second got v=%0b pc=%h want v=1 pc=104", bus.out_valid, bus.out_pc); end
    checks++; if (bus.out_instr !== 32'hAAAA_0104) begin errors++; $display("FAIL bp_second_instr got %h want aaaa0104", bus.out_instr); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drain got %0b want 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_flush_two();
    fill_two();
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h108;
    bus.in_instr  = 32'hAAAA_0108;
    bus.out_ready = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_two_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_two_ready got %0b want 1", bus.in_ready); end
    repeat (3) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_two_no_108 got v=%0b pc=%h want v=0", bus.out_valid, bus.out_pc); end
    end
  endtask

  task automatic test_flush_one_drops_accept();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h200;
    bus.in_instr  = 32'hBBBB_0200;
    tick();
    flush        = 1'b1;
    bus.in_pc    = 32'h204;
    bus.in_instr = 32'hBBBB_0204;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_one got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_dropped got v=%0b pc=%h want v=0", bus.out_valid, bus.out_pc); end
  endtask

  task automatic test_reset_mid_stream();
    fill_two();
    #3;
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset_ctrl got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
      errors++; $display("FAIL async_reset_data got pc=%h instr=%h want 0 0", bus.out_pc, bus.out_instr);
    end
    tick();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h300;
    bus.in_instr  = 32'hCCCC_0300;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300) begin
      errors++; $display("FAIL post_reset_beat got v=%0b pc=%h want v=1 pc=300", bus.out_valid, bus.out_pc);
    end
    tick();
  endtask

  task automatic test_streaming();
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] stall_pc, stall_instr;
    logic        stall_prev, in_fire, out_fire;
    int          delivered, cycles;
    next_pc    = 32'h1000;
    stall_prev = 1'b0;
    stall_pc   = '0;
    stall_instr = '0;
    delivered  = 0;
    cycles     = 0;
    while (delivered < 10000 && cycles < 60000) begin
      bus.in_valid  = ($urandom_range(0, 99) < 70);
      bus.in_pc     = next_pc;
      bus.in_instr  = next_pc ^ 32'hA5A5_0000;
      bus.out_ready = ($urandom_range(0, 99) < 65);
      checks++; if (bus.in_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL stream_in_ready got %0b want %0b (held %0d)", bus.in_ready, exp_q.size() < 2, exp_q.size());
      end
      checks++; if (bus.out_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL stream_out_valid got %0b want %0b", bus.out_valid, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        checks++; if (bus.out_pc !== exp_q[0] || bus.out_instr !== (exp_q[0] ^ 32'hA5A5_0000)) begin
          errors++; $display("FAIL stream_order got pc=%h instr=%h want pc=%h", bus.out_pc, bus.out_instr, exp_q[0]);
        end
      end
      if (stall_prev) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== stall_pc || bus.out_instr !== stall_instr) begin
          errors++; $display("FAIL stream_stability got v=%0b pc=%h want v=1 pc=%h", bus.out_valid, bus.out_pc, stall_pc);
        end
      end
      in_fire     = bus.in_valid & (exp_q.size() < 2);
      out_fire    = (exp_q.size() > 0) & bus.out_ready;
      stall_prev  = (exp_q.size() > 0) & !bus.out_ready;
      stall_pc    = bus.out_pc;
      stall_instr = bus.out_instr;
      if (out_fire) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (in_fire) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
      tick();
      cycles++;
    end
    checks++; if (delivered < 10000) begin errors++; $display("FAIL stream_timeout got %0d beats want 10000", delivered); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL stream_drain got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_flush_two();
    test_flush_one_drops_accept();
    test_reset_mid_stream();
    test_streaming();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
